// File: rtl/cordic_sched.sv
// ---------------------------------------------------------------------------
// cordic_sched
//
// Shares one pipelined CORDIC core among NUM_REQ requesters. A round-robin
// arbiter selects one requester per cycle and registers its operand in the
// issue register, which feeds the core. A {valid, id} tag pipeline runs in
// lock-step with the core. Each result is returned on one ID-tagged
// response port. Response backpressure deasserts core_en, which freezes the
// core, the issue register and the tag pipeline together, so no result is
// ever lost.
//
// Configuration macro:
//   CORDIC_SCHED_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins,
//                                            and there is no `last` register
//                               undefined -> round-robin (default)
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   CORE_LAT  core latency in enabled cycles (1..32)
//   ID_W      response ID width (derived)
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid       per-requester request valid
//   req_ready       per-requester accept, at most one bit set
//   req_func        per-requester function (0 = ROTATION, 1 = VECTOR)
//   req_data        per-requester {x,y,z}, requester i at [48i+47:48i]
//   core_in_valid   issue register holds an operation
//   core_in_func    registered function to the core
//   core_in_data    registered operand to the core
//   core_en         global core pipeline enable
//   core_out_data   core result, aligned to tag stage CORE_LAT
//   rsp_valid/rsp_ready/rsp_id/rsp_data  response handshake, tagged result
//   inflight        operations held in the issue reg, tag pipe and output reg
//   busy            inflight != 0
// ---------------------------------------------------------------------------
module cordic_sched #(
  parameter int NUM_REQ  = 4,
  parameter int CORE_LAT = 16,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_func,
  input  logic [NUM_REQ*48-1:0] req_data,
  output logic                  core_in_valid,
  output logic                  core_in_func,
  output logic [47:0]           core_in_data,
  output logic                  core_en,
  input  logic [53:0]           core_out_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [53:0]           rsp_data,
  output logic [5:0]            inflight,
  output logic                  busy
);

  typedef logic [47:0] cordic_data_t;
  typedef logic [53:0] cordic_output_data_t;

  cordic_data_t        req_data_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_any;
  logic                issue_adv;
  logic                req_hs;
  logic                rsp_hs;
  logic                out_load;
  logic [ID_W-1:0]     issue_id;
  logic [CORE_LAT:1]   tag_v;
  logic [ID_W-1:0]     tag_id [1:CORE_LAT];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_data_arr[gi] = req_data[48*gi +: 48];
  end

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
  // Scan from the top so the lowest valid index is the last one written.
  always_comb begin
    // NOTE: every combinational output gets a default before any
    // conditional assignment; otherwise the tool infers a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end
`else
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] cand;

  // Search last+1, last+2, ... with wrap-around. The first valid hit wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any
    // conditional assignment; otherwise the tool infers a latch.
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // The pointer moves only on a completed handshake. A grant that stays
  // stalled keeps its turn.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples pre-edge values regardless of block ordering.
    if (!rst_n)      last <= ID_W'(NUM_REQ - 1);
    else if (req_hs) last <= grant_idx;
  end
`endif

  assign grant = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;

  // -------------------------------------------------------------------------
  // Stall and request handshake
  // -------------------------------------------------------------------------
  // The only stall source is a finished result at the last tag stage that
  // cannot move into the occupied, unaccepted output register.
  assign core_en   = !(tag_v[CORE_LAT] && rsp_valid && !rsp_ready);
  // An empty issue register can load even while the core is frozen.
  assign issue_adv = !core_in_valid || core_en;
  // Gating with rst_n keeps requesters from seeing an accept while in reset.
  assign req_ready = grant & {NUM_REQ{issue_adv && rst_n}};
  assign req_hs    = |req_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  // -------------------------------------------------------------------------
  // Issue register (tag stage 0)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_in_valid <= 1'b0;
      core_in_func  <= 1'b0;
      core_in_data  <= '0;
      issue_id      <= '0;
    end else if (issue_adv) begin
      // When it advances without a new handshake, the register empties.
      core_in_valid <= req_hs;
      core_in_func  <= req_hs ? req_func[grant_idx] : 1'b0;
      core_in_data  <= req_hs ? req_data_arr[grant_idx] : '0;
      issue_id      <= req_hs ? grant_idx : '0;
    end
  end

  // -------------------------------------------------------------------------
  // Tag pipeline, stages 1..CORE_LAT, lock-step with the core
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
    end else if (core_en) begin
      tag_v[1] <= core_in_valid;
      for (int s = 2; s <= CORE_LAT; s++) tag_v[s] <= tag_v[s-1];
    end
  end

  // NOTE: the ID shift register has no reset. Each ID is only used when its
  // tag_v bit is set, and tag_v is reset, so reset flops here would buy nothing.
  always_ff @(posedge clk) begin
    if (core_en) begin
      tag_id[1] <= issue_id;
      for (int s = 2; s <= CORE_LAT; s++) tag_id[s] <= tag_id[s-1];
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  // The load condition is exactly the case where core_en is high with a
  // valid last stage. Whatever leaves the tag pipe is always captured.
  assign out_load = tag_v[CORE_LAT] && (!rsp_valid || rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (out_load) begin
      rsp_valid <= 1'b1;
      rsp_id    <= tag_id[CORE_LAT];
      rsp_data  <= core_out_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // Occupancy
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      unique case ({req_hs, rsp_hs})
        2'b10:   inflight <= inflight + 6'd1;
        2'b01:   inflight <= inflight - 6'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign busy = (inflight != 6'd0);

endmodule

// File: tb/tb_cordic_sched.sv
// ---------------------------------------------------------------------------
// tb_cordic_sched
//
// Bench for cordic_sched with NUM_REQ=4 and CORE_LAT=16. A stand-in core
// (a CORE_LAT-deep enabled shift register that applies a fixed transform)
// drives core_out_data. A monitor keeps a FIFO of expected {id, result}
// records filled on every request handshake. It also keeps its own
// arbitration pointer and an occupancy count.
// ---------------------------------------------------------------------------
module tb_cordic_sched;

  localparam int NUM_REQ  = 4;
  localparam int CORE_LAT = 16;
  localparam int ID_W     = 2;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_func  = '0;
  logic [NUM_REQ*48-1:0] req_data  = '0;
  logic                  core_in_valid;
  logic                  core_in_func;
  logic [47:0]           core_in_data;
  logic                  core_en;
  logic [53:0]           core_out_data;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [ID_W-1:0]       rsp_id;
  logic [53:0]           rsp_data;
  logic [5:0]            inflight;
  logic                  busy;

  always #5 clk = ~clk;

  cordic_sched #(.NUM_REQ(NUM_REQ), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_data(req_data),
    .core_in_valid(core_in_valid), .core_in_func(core_in_func),
    .core_in_data(core_in_data), .core_en(core_en),
    .core_out_data(core_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .inflight(inflight), .busy(busy)
  );

  // ---------------- stand-in core ----------------
  function automatic logic [53:0] core_fn(input logic f, input logic [47:0] d);
    return {f, 5'b10110, d ^ 48'h5a5a_3c3c_0f0f};
  endfunction

  logic [53:0] core_pipe [1:CORE_LAT];
  always @(posedge clk) begin
    if (core_en) begin
      core_pipe[1] <= core_fn(core_in_func, core_in_data);
      for (int s = 2; s <= CORE_LAT; s++) core_pipe[s] <= core_pipe[s-1];
    end
  end
  assign core_out_data = core_pipe[CORE_LAT];

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [53:0]     data;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        mon_e;
  int          model_last = NUM_REQ - 1;
  int          model_cnt  = 0;
  int          mon_g;
  logic        hold_prev = 1'b0;
  logic [ID_W-1:0] hold_id;
  logic [53:0]     hold_data;

  function automatic int exp_grant(input logic [NUM_REQ-1:0] v, input int last);
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
`else
    for (int k = 1; k <= NUM_REQ; k++) if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`endif
    return -1;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    model_last = NUM_REQ - 1;
    model_cnt  = 0;
    hold_prev  = 1'b0;
  endtask

  // Monitor: samples at the falling edge. Handshakes seen here take effect
  // on the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin
        mon_g = exp_grant(req_valid, model_last);
        check("grant", 64'(req_ready), 64'(1 << mon_g));
      end
      check("inflight", 64'(inflight), 64'(model_cnt));
      check("busy", 64'(busy), 64'(model_cnt != 0));
      if (hold_prev) begin
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_id", 64'(rsp_id), 64'(hold_id));
        check("hold_data", 64'(rsp_data), 64'(hold_data));
      end
      hold_prev = rsp_valid && !rsp_ready;
      hold_id   = rsp_id;
      hold_data = rsp_data;
      if (|(req_valid & req_ready)) begin
        mon_g = exp_grant(req_valid, model_last);
        exp_q.push_back('{id: ID_W'(mon_g), data: core_fn(req_func[mon_g], req_data[48*mon_g +: 48])});
        model_last = mon_g;
        model_cnt++;
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
          check("rsp_data", 64'(rsp_data), 64'(mon_e.data));
          model_cnt--;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    req_valid[i] = 1'b1;
    req_func[i]  = 1'($urandom_range(0, 1));
    req_data[48*i +: 48] = {16'($urandom), 32'($urandom)};
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_core_in_valid"}, 64'(core_in_valid), 64'd0);
    check({tag, "_core_in_func"}, 64'(core_in_func), 64'd0);
    check({tag, "_core_in_data"}, 64'(core_in_data), 64'd0);
    check({tag, "_core_en"}, 64'(core_en), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    check({tag, "_inflight"}, 64'(inflight), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset(input bit with_checks, input string tag);
    req_valid = '0;
    rst_n     = 1'b0;
    model_clear();
    #1;
    if (with_checks) reset_checks(tag);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (model_cnt == 0 && !rsp_valid) done = 1'b1;
    end
    check({tag, "_drained"}, 64'(done), 64'd1);
    check({tag, "_drain_inflight"}, 64'(inflight), 64'd0);
  endtask

  // ---------------- arbitration table ----------------
  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] exp_rr;
    logic [NUM_REQ-1:0] exp_fp;
  } arb_vec_t;

  arb_vec_t           tbl [17];
  logic [NUM_REQ-1:0] hs_prev;
  logic [47:0]        single_data;
  logic [53:0]        bp_held;
  int                 bp_sent;
  int                 lat;
  int                 infl;
  bit                 seen;
  int                 cnt;
  logic [NUM_REQ-1:0] hs;

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0100, 4'b0001};
    tbl[3]  = '{4'b1111, 4'b1000, 4'b0001};
    tbl[4]  = '{4'b1111, 4'b0001, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010, 4'b0001};
    tbl[6]  = '{4'b1111, 4'b0100, 4'b0001};
    tbl[7]  = '{4'b1111, 4'b1000, 4'b0001};
    tbl[8]  = '{4'b0111, 4'b0001, 4'b0001};
    tbl[9]  = '{4'b0110, 4'b0010, 4'b0010};
    tbl[10] = '{4'b0100, 4'b0100, 4'b0100};
    tbl[11] = '{4'b1000, 4'b1000, 4'b1000};
    tbl[12] = '{4'b1001, 4'b0001, 4'b0001};
    tbl[13] = '{4'b1000, 4'b1000, 4'b1000};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000};
    tbl[15] = '{4'b1010, 4'b0010, 4'b0010};
    tbl[16] = '{4'b1000, 4'b1000, 4'b1000};

    #2;
    do_reset(1'b1, "rst");

    // ---- arbitration table: one row per cycle, no stall ----
    hs_prev = '0;
    for (int k = 0; k < 17; k++) begin
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tbl[k].valid[i]) begin
          if (!req_valid[i] || hs_prev[i]) new_req(i);
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      @(negedge clk);
`ifdef CORDIC_SCHED_FIXED_PRIO_EN
      check($sformatf("arb_row%0d", k), 64'(req_ready), 64'(tbl[k].exp_fp));
`else
      check($sformatf("arb_row%0d", k), 64'(req_ready), 64'(tbl[k].exp_rr));
`endif
      hs_prev = req_valid & req_ready;
    end
    drain("arb");

    // ---- single request latency ----
    step();
    do_reset(1'b0, "rst2");
    single_data  = {16'h4000, 16'h0000, 16'h2000};
    req_valid[2] = 1'b1;
    req_func[2]  = 1'b0;
    req_data[2*48 +: 48] = single_data;
    @(negedge clk);
    check("single_ready", 64'(req_ready), 64'b0100);
    step();
    req_valid = '0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("single_latency", 64'(lat), 64'(CORE_LAT + 1));
    check("single_id", 64'(rsp_id), 64'd2);
    check("single_data", 64'(rsp_data), 64'(core_fn(1'b0, single_data)));
    @(posedge clk);
    @(negedge clk);
    check("single_inflight_end", 64'(inflight), 64'd0);

    // ---- backpressure: 20 back-to-back requests from requester 1 ----
    step();
    rsp_ready = 1'b0;
    fork
      begin
        bp_sent = 0;
        new_req(1);
        for (int g = 0; g < 400 && bp_sent < 20; g++) begin
          @(negedge clk);
          if (req_ready[1]) begin
            bp_sent++;
            @(posedge clk);
            #1;
            if (bp_sent < 20) new_req(1);
            else req_valid[1] = 1'b0;
          end
        end
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
          @(negedge clk);
          if (rsp_valid) seen = 1'b1;
        end
        check("bp_first_rsp", 64'(seen), 64'd1);
        bp_held = rsp_data;
        for (int c = 0; c < 10; c++) begin
          if (c > 0) @(negedge clk);
          check("bp_core_en", 64'(core_en), 64'd0);
          check("bp_req_ready", 64'(req_ready), 64'd0);
          check("bp_rsp_stable", 64'(rsp_data), 64'(bp_held));
          check("bp_inflight", 64'(inflight), 64'(CORE_LAT + 2));
        end
        step();
        rsp_ready = 1'b1;
        infl = 0;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          if (j == 0) begin
            check("recover_core_en", 64'(core_en), 64'd1);
            check("recover_req_ready", 64'(req_ready), 64'b0010);
            infl = int'(inflight);
          end
          if (j == 1) check("simul_inflight", 64'(inflight), 64'(infl));
          check("b2b_rsp_valid", 64'(rsp_valid), 64'd1);
        end
        @(negedge clk);
        check("b2b_end", 64'(rsp_valid), 64'd0);
      end
    join
    drain("bp");

    // ---- randomized traffic with random backpressure ----
    hs_prev = '0;
    for (int c = 0; c < 800; c++) begin
      step();
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || hs_prev[i]) begin
          if ($urandom_range(0, 99) < 45) new_req(i);
          else req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 65);
      @(negedge clk);
      hs_prev = req_valid & req_ready;
    end
    drain("rand");

    // ---- reset with five operations in flight ----
    step();
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) new_req(i);
    cnt = 0;
    for (int g = 0; g < 100 && cnt < 5; g++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      if (hs != '0) cnt++;
      step();
      if (cnt < 5) begin
        for (int i = 0; i < NUM_REQ; i++) if (hs[i]) new_req(i);
      end
    end
    req_valid = '0;
    check("mr_inflight_before", 64'(inflight), 64'd5);
    do_reset(1'b1, "mr");
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("mr_no_rsp", 64'(seen), 64'd0);
    step();
    for (int i = 0; i < NUM_REQ; i++) new_req(i);
    @(negedge clk);
    check("mr_first_grant", 64'(req_ready), 64'b0001);
    drain("mr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
